// File: rtl/regfile_mp_sb.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Optional same-cycle write-to-read bypass: REGFILE_WR_BYPASS_EN.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
  output logic [NUM_RD*DATA_W-1:0]      rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]      wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]      wr_data,
  input  logic                          rsv_en,
  input  logic [ADDR_W-1:0]             rsv_addr,
  input  logic                          flush,
  output logic [$clog2(NUM_REGS+1)-1:0] pend_cnt
);

  localparam int CNT_W = $clog2(NUM_REGS + 1);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busyNext;
  logic [CNT_W-1:0]    cntNext;

  logic [ADDR_W-1:0] wrA  [NUM_WR];
  logic [DATA_W-1:0] wrD  [NUM_WR];
  logic              wrOk [NUM_WR];

  // x0 and anything beyond the implemented registers behave as a sink
  function automatic logic validAddr(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  for (genvar w = 0; w < NUM_WR; w++) begin : gWr
    assign wrA[w]  = wr_addr[w*ADDR_W +: ADDR_W];
    assign wrD[w]  = wr_data[w*DATA_W +: DATA_W];
    assign wrOk[w] = wr_en[w] && validAddr(wrA[w]);
  end

  always_comb begin
    busyNext = busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wrOk[w]) busyNext[wrA[w]] = 1'b0;
    end
    // a reserve marks a newer producer, so it overrides a retiring write
    if (rsv_en && validAddr(rsv_addr)) busyNext[rsv_addr] = 1'b1;
    if (flush) busyNext = '0;
    busyNext[0] = 1'b0;
  end

  always_comb begin
    cntNext = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cntNext = cntNext + CNT_W'(busyNext[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      // ascending order: the highest-indexed port lands last
      for (int w = 0; w < NUM_WR; w++) begin
        if (wrOk[w]) regs[wrA[w]] <= wrD[w];
      end
      busy     <= busyNext;
      pend_cnt <= cntNext;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdD;
    logic              rdB;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rdD = '0;
      rdB = 1'b0;
      if (validAddr(ra)) begin
        rdD = regs[ra];
        rdB = busy[ra];
      end
`ifdef REGFILE_WR_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wrOk[w] && (wrA[w] == ra)) begin
          rdD = wrD[w];
          rdB = 1'b0;
        end
      end
`else
`endif
    end

    assign rd_data[k*DATA_W +: DATA_W] = rdD;
    assign rd_busy[k]                  = rdB;
  end

endmodule
